onchip_ram_pipelined: RTL and testbench

- Parametrised on-chip RAM with an Avalon-MM slave interface; next generation of the Nios II system's single-port on-chip memory.
- Adds explicit read/write strobes, pipelined reads with readdatavalid, and waitrequest back-pressure.
- Adds a post-reset clear sequencer, out-of-range address detection, and clock-enable/reset_req stall handling.
- Instantiated in the CPU subsystem as program/data memory or as a signal-path scratch buffer.

---
 rtl/onchip_ram_pkg.sv | 22 ++
 rtl/onchip_ram_core.sv | 36 +++
 rtl/onchip_ram_pipelined.sv | 151 +++++++++++++++
 tb/tb_onchip_ram_pipelined.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM.
package onchip_ram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

    function automatic int unsigned bytes_w(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled single-port array with synchronous read; maps onto block RAM.
module onchip_ram_core
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 35000,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [IDX_W-1:0]          addr_i,
    input  logic [bytes_w(DATA_W)-1:0] be_i,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         rdata_o
);
    localparam int unsigned BYTES_W = bytes_w(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < BYTES_W; k++) begin
                if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM: clear sequencer, range check, write-first bypass, read pipeline.
// Define ONCHIP_RAM_OUTREG_EN to add an output register (read latency 2).
module onchip_ram_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int unsigned        DATA_W         = 32,
    parameter int unsigned        DEPTH          = 35000,
    parameter int unsigned        ADDR_W         = 16,
    parameter bit                 CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_done,
    output logic                  addr_error
);
    localparam int unsigned BYTES_W = bytes_w(DATA_W);
    localparam int unsigned IDX_W   = clog2(DEPTH);

    state_e               state_q;
    logic [ADDR_W-1:0]    clr_q;
    logic                 init_done_q;
    logic                 en_c, ready_c, accept_c, in_range_c, wr_acc_c, rd_acc_c, err_c;
    logic                 core_we_c, core_re_c;
    logic [IDX_W-1:0]     core_addr_c;
    logic [BYTES_W-1:0]   core_be_c;
    logic [DATA_W-1:0]    core_wd_c, core_rdata;
    logic                 wr_vld_q, rsp_vld_q, oor_q, err_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q, byp_data_q, rd_data_c;
    logic [BYTES_W-1:0]   wr_be_q, byp_be_q;

    assign en_c        = clken & ~reset_req;
    assign ready_c     = (state_q == ST_READY);
    assign waitrequest = ~reset_n | ~ready_c | ~en_c;
    assign accept_c    = chipselect & ~waitrequest;
    assign in_range_c  = 32'(address) < 32'(DEPTH);
    assign wr_acc_c    = accept_c & write & in_range_c;
    assign rd_acc_c    = accept_c & read & ~write;
    assign err_c       = accept_c & (((read | write) & ~in_range_c) | (read & write));

    // Clear sequencer: one word per enabled cycle, then serve commands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
            clr_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= ready_c;
            if (en_c && state_q == ST_INIT) begin
                if (32'(clr_q) == DEPTH - 1) state_q <= ST_READY;
                else                         clr_q   <= clr_q + ADDR_W'(1);
            end
        end
    end

    assign init_done   = init_done_q;
    assign core_we_c   = en_c & (~ready_c | wr_acc_c);
    assign core_re_c   = rd_acc_c & in_range_c;
    assign core_addr_c = ready_c ? address[IDX_W-1:0] : clr_q[IDX_W-1:0];
    assign core_be_c   = ready_c ? byteenable : '1;
    assign core_wd_c   = ready_c ? writedata : INIT_VALUE;

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .clk     (clk),
        .we_i    (core_we_c),
        .re_i    (core_re_c),
        .addr_i  (core_addr_c),
        .be_i    (core_be_c),
        .wdata_i (core_wd_c),
        .rdata_o (core_rdata)
    );

    // Response stage; read-side state only moves on an accepted read so readdata holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            rsp_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            oor_q      <= 1'b1;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else if (en_c) begin
            wr_vld_q  <= wr_acc_c;
            rsp_vld_q <= rd_acc_c;
            err_q     <= err_c;
            if (wr_acc_c) begin
                wr_addr_q <= address;
                wr_data_q <= writedata;
                wr_be_q   <= byteenable;
            end
            if (rd_acc_c) begin
                oor_q      <= ~in_range_c;
                byp_data_q <= wr_data_q;
                byp_be_q   <= (wr_vld_q && wr_addr_q == address) ? wr_be_q : '0;
            end
        end
    end

    always_comb begin
        rd_data_c = core_rdata;
        for (int k = 0; k < BYTES_W; k++) begin
            if (byp_be_q[k]) rd_data_c[8*k +: 8] = byp_data_q[8*k +: 8];
        end
        if (oor_q) rd_data_c = '0;
    end

`ifdef ONCHIP_RAM_OUTREG_EN
    logic [DATA_W-1:0] out_data_q;
    logic              out_vld_q, out_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else if (en_c) begin
            out_vld_q <= rsp_vld_q;
            out_err_q <= err_q;
            if (rsp_vld_q) out_data_q <= rd_data_c;
        end
    end

    assign readdata      = out_data_q;
    assign readdatavalid = out_vld_q & en_c;
    assign addr_error    = out_err_q & en_c;
`else
    assign readdata      = rd_data_c;
    assign readdatavalid = rsp_vld_q & en_c;
    assign addr_error    = err_q & en_c;
`endif

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Scoreboard bench for onchip_ram_pipelined (DEPTH=16, fill A5A5A5A5).
module tb_onchip_ram_pipelined;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] FILL  = 32'hA5A5A5A5;
`ifdef ONCHIP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic        clken = 1'b1, reset_req = 1'b0;
    logic [15:0] address = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest, init_done, addr_error;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_fail = 0, en_cyc = 0, err_seen = 0, err_exp = 0;

    onchip_ram_pipelined #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(16),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE(FILL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .init_done(init_done), .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    // Count enabled clock edges; response latency is measured in these.
    always @(posedge clk) if (clken && !reset_req) en_cyc <= en_cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every readdatavalid.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (addr_error) err_seen++;
        if (readdatavalid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rdv: got readdata %h expected no response at %0t", readdata, $time);
            end else begin
                e = sb_q.pop_front();
                chk("rdata", readdata, e.data);
                chk("rsp_err", 32'(addr_error), 32'(e.err));
                chk("latency", 32'(en_cyc), 32'(e.cyc));
            end
        end
    end

    task automatic cmd(input logic rd, input logic wr, input logic [15:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp, input logic eerr);
        int waits;
        waits = 0;
        chipselect = 1'b1; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
        @(negedge clk);
        while (waitrequest && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("accept", 32'(waitrequest), 32'd0);
        if (!waitrequest) begin
            if (rd && !wr) sb_q.push_back('{exp, eerr, en_cyc + LAT});
            if (eerr) err_exp++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stall(input bit use_req);
        if (use_req) reset_req = 1'b1;
        else         clken     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_wait", 32'(waitrequest), 32'd1);
            chk("stall_rdv", 32'(readdatavalid), 32'd0);
            @(posedge clk); #1;
        end
        clken = 1'b1;
        reset_req = 1'b0;
    endtask

    task automatic check_clear();
        int n;
        n = 0;
        @(negedge clk);
        chk("init_done_early", 32'(init_done), 32'd0);
        while (waitrequest && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", 32'(n), 32'(DEPTH));
        chk("init_done_lag", 32'(init_done), 32'd0);
        @(negedge clk);
        chk("init_done", 32'(init_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_rdv", 32'(readdatavalid), 32'd0);
        chk("rst_wait", 32'(waitrequest), 32'd1);
        chk("rst_err", 32'(addr_error), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_clear();

        for (int i = 0; i < 16; i++) cmd(1'b1, 1'b0, 16'(i), 4'h0, 32'd0, FILL, 1'b0);
        idle(4);

        // Byte enables, bypass on consecutive write/read, zero-enable no-op.
        cmd(1'b0, 1'b1, 16'd5, 4'hF, 32'h11223344, 32'd0, 1'b0);
        cmd(1'b0, 1'b1, 16'd5, 4'b0101, 32'hFFFFFFFF, 32'd0, 1'b0);
        cmd(1'b1, 1'b0, 16'd5, 4'h0, 32'd0, 32'h11FF33FF, 1'b0);
        idle(1);
        cmd(1'b0, 1'b1, 16'd5, 4'h0, 32'h00000000, 32'd0, 1'b0);
        idle(1);
        cmd(1'b1, 1'b0, 16'd5, 4'h0, 32'd0, 32'h11FF33FF, 1'b0);

        // Streaming reads.
        for (int i = 0; i < 8; i++) cmd(1'b0, 1'b1, 16'(i), 4'hF, 32'hC0DE0000 + 32'(i), 32'd0, 1'b0);
        idle(1);
        for (int i = 0; i < 8; i++) cmd(1'b1, 1'b0, 16'(i), 4'h0, 32'd0, 32'hC0DE0000 + 32'(i), 1'b0);
        idle(2);

        // Stalls inside a read burst.
        for (int i = 0; i < 8; i++) begin
            cmd(1'b1, 1'b0, 16'(i), 4'h0, 32'd0, 32'hC0DE0000 + 32'(i), 1'b0);
            if (i == 3) stall(1'b0);
            if (i == 5) stall(1'b1);
        end
        idle(4);
        chk("sb_drained_1", 32'(sb_q.size()), 32'd0);

        // Out-of-range and read+write collision.
        cmd(1'b0, 1'b1, 16'd20, 4'hF, 32'hDEADBEEF, 32'd0, 1'b1);
        idle(1);
        cmd(1'b1, 1'b0, 16'd4, 4'h0, 32'd0, 32'hC0DE0004, 1'b0);
        cmd(1'b1, 1'b0, 16'd20, 4'h0, 32'd0, 32'd0, 1'b1);
        cmd(1'b1, 1'b1, 16'd6, 4'hF, 32'h12345678, 32'd0, 1'b1);
        idle(1);
        cmd(1'b1, 1'b0, 16'd6, 4'h0, 32'd0, 32'h12345678, 1'b0);
        idle(3);
        @(negedge clk);
        chk("readdata_hold", readdata, 32'h12345678);
        @(posedge clk); #1;
        chk("sb_drained_2", 32'(sb_q.size()), 32'd0);
        chk("err_pulses", 32'(err_seen), 32'(err_exp));

        // Reset in the middle of the clear sequence.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_wait", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_clear();
        cmd(1'b1, 1'b0, 16'd5, 4'h0, 32'd0, FILL, 1'b0);
        cmd(1'b1, 1'b0, 16'd10, 4'h0, 32'd0, FILL, 1'b0);
        idle(4);
        chk("sb_drained_3", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
